mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Load/store unit for the 16-bit CPU. It sits between the execute stage and the data memory. It accepts one memory request at a time over a valid/ready handshake and drives the data memory's addr/wrData/memRead/memWrite pins. It returns load data to writeback as a one-cycle response pulse. It adds byte loads (sign-extended) and byte stores (read-modify-write) on top of the word-only data memory, and flags misaligned word accesses.

## Interface
Parameters:
- ADDR_W, 16, byte-address width of requests
- DATA_W, 16, data width (fixed at 16; byte lanes assume 16)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request (high only in IDLE)
- req_op  in  2  00 LW, 01 SW, 10 LB, 11 SB
- req_addr  in  16  byte address
- req_wdata  in  16  store data (SB uses [7:0])
- req_rd  in  4  destination register tag for loads
- mem_addr  out  16  word address to data memory: {1'b0, addr[15:1]}
- mem_wrData  out  16  write data to data memory
- mem_memRead  out  1  read enable
- mem_memWrite  out  1  write enable (memory writes on the clk edge)
- mem_rdData  in  16  combinational read data from data memory
- resp_valid  out  1  one-cycle completion pulse, every accepted request
- resp_load  out  1  with resp_valid: register write required (LW/LB, no error)
- resp_rd  out  4  registered req_rd
- resp_data  out  16  load result
- resp_err  out  1  with resp_valid: misaligned LW/SW

## Operation
- States: IDLE, ACCESS, MERGE.
- IDLE: req_ready=1. When req_valid&req_ready at a clock edge, register op, addr, wdata and rd, then go to ACCESS.
- ACCESS: memory pins are driven from the registered request only. Inputs are never passed through combinationally.
  - LW, addr[0]=0: memRead=1. At the edge, resp_data<=mem_rdData, resp_valid=1, resp_load=1. Next state IDLE.
  - SW, addr[0]=0: memWrite=1, wrData=wdata. The write lands at the edge. resp_valid=1, resp_load=0. Next state IDLE.
  - LW/SW, addr[0]=1: no memRead and no memWrite. resp_valid=1, resp_err=1, resp_load=0, resp_data=0. Next state IDLE.
  - LB: memRead=1. The selected byte is [7:0] if addr[0]=0, else [15:8]. It is sign-extended to 16 bits into resp_data. resp_valid=1, resp_load=1. Next state IDLE.
  - SB: memRead=1. Capture mem_rdData into the merge register. Next state MERGE.
- MERGE (SB only): memWrite=1. wrData is the merge word with byte lane addr[0] replaced by wdata[7:0]. resp_valid=1, resp_load=0. Next state IDLE.
- When memRead=0 and memWrite=0: mem_addr=0 and mem_wrData=0.
- Response outputs are registered and valid for exactly the one cycle after the completing edge. There is no downstream backpressure.
- A new request may be accepted in the same cycle resp_valid is high. The unit is back in IDLE then.
- Reset (async, any state): state<=IDLE and all outputs go to 0 immediately, except req_ready=1. An in-progress SB aborts with no write. A read already latched into the merge register is discarded.

## Timing
- Request accepted at edge N.
- LW/LB/SW/misaligned: ACCESS occupies cycle N→N+1. resp_valid is high in cycle N+1→N+2. Throughput is 1 request per 2 cycles.
- SB: read in cycle N→N+1, write in MERGE N+1→N+2. The memory word is updated at edge N+2. resp_valid is high in cycle N+2→N+3. Throughput is 1 per 3 cycles.
- memRead and memWrite are never both high in the same cycle.
- req_ready is low in ACCESS and MERGE. Changes on request inputs there are ignored.

## Test plan
- Reset, then LW addr 0x0000: mem_memRead high one cycle at mem_addr 0. resp_data=0x02BC, resp_load=1, resp_err=0, resp_rd equals the issued tag.
- After reset, LB addr 0x0000 → resp_data=0xFFBC. LB addr 0x0001 → resp_data=0x0002.
- SW addr 0x0002 data 0x1234, then SB addr 0x0003 data 0x00A5:
  - SW: mem_addr=1 and one memWrite cycle.
  - SB: one memRead cycle, then one memWrite cycle with wrData=0xA534.
  - A following LW 0x0002 returns 0xA534.
- LW addr 0x0005 and SW addr 0x0007: no memRead or memWrite cycle. resp_valid with resp_err=1, resp_load=0, resp_data=0. Memory is unchanged.
- Back-to-back: req_valid held high with 3 LWs → accepted on every other edge. req_ready is low in each ACCESS cycle. Each resp_valid pulses exactly once with correct data.
- Assert rst low during an SB's MERGE cycle: memWrite drops immediately and the target word is unchanged. After release, req_ready=1 and resp_valid=0.

Source files
------------

// File: rtl/mem_access_unit.sv
// Load/store unit between execute and a word-only data memory. It adds sign-extended byte loads,
// read-modify-write byte stores, and flags misaligned word accesses. One request is in flight at a time.
module mem_access_unit #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [3:0]        req_rd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wrData,
  output logic              mem_memRead,
  output logic              mem_memWrite,
  input  logic [DATA_W-1:0] mem_rdData,
  output logic              resp_valid,
  output logic              resp_load,
  output logic [3:0]        resp_rd,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_err
);

  localparam logic [1:0] OP_LW = 2'b00;
  localparam logic [1:0] OP_SW = 2'b01;
  localparam logic [1:0] OP_LB = 2'b10;
  localparam logic [1:0] OP_SB = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_MERGE} state_t;

  state_t            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        rd_q, rd_d;
  logic [DATA_W-1:0] merge_q, merge_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_load_q, resp_load_d;
  logic [DATA_W-1:0] resp_data_q, resp_data_d;
  logic              resp_err_q, resp_err_d;

  logic              rd_en, wr_en;
  logic [DATA_W-1:0] wr_dat;
  logic [7:0]        byte_sel;
  logic              misaligned;

  assign byte_sel   = addr_q[0] ? mem_rdData[15:8] : mem_rdData[7:0];
  // Only word ops care about alignment; op[1]=0 selects LW/SW.
  assign misaligned = addr_q[0] & ~op_q[1];

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rd_d         = rd_q;
    merge_d      = merge_q;
    resp_valid_d = 1'b0;
    resp_load_d  = 1'b0;
    resp_data_d  = '0;
    resp_err_d   = 1'b0;
    rd_en        = 1'b0;
    wr_en        = 1'b0;
    wr_dat       = '0;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          op_d    = req_op;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          rd_d    = req_rd;
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        state_d = S_IDLE;
        if (misaligned) begin
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
        end else begin
          case (op_q)
            OP_LW: begin
              rd_en        = 1'b1;
              resp_valid_d = 1'b1;
              resp_load_d  = 1'b1;
              resp_data_d  = mem_rdData;
            end
            OP_SW: begin
              wr_en        = 1'b1;
              wr_dat       = wdata_q;
              resp_valid_d = 1'b1;
            end
            OP_LB: begin
              rd_en        = 1'b1;
              resp_valid_d = 1'b1;
              resp_load_d  = 1'b1;
              resp_data_d  = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
            end
            OP_SB: begin
              rd_en   = 1'b1;
              merge_d = mem_rdData;
              state_d = S_MERGE;
            end
            default: ;
          endcase
        end
      end
      S_MERGE: begin
        wr_en        = 1'b1;
        wr_dat       = addr_q[0] ? {wdata_q[7:0], merge_q[7:0]} : {merge_q[15:8], wdata_q[7:0]};
        resp_valid_d = 1'b1;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      op_q         <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rd_q         <= '0;
      merge_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_load_q  <= 1'b0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rd_q         <= rd_d;
      merge_q      <= merge_d;
      resp_valid_q <= resp_valid_d;
      resp_load_q  <= resp_load_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign req_ready    = (state_q == S_IDLE);
  assign mem_memRead  = rd_en;
  assign mem_memWrite = wr_en;
  assign mem_addr     = (rd_en | wr_en) ? {1'b0, addr_q[ADDR_W-1:1]} : '0;
  assign mem_wrData   = wr_dat;
  assign resp_valid   = resp_valid_q;
  assign resp_load    = resp_load_q;
  assign resp_rd      = rd_q;
  assign resp_data    = resp_data_q;
  assign resp_err     = resp_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed scenarios plus random traffic, checked against a word-array
// model of the data memory and the load/store rules.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'b00;
  logic [15:0] req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic [3:0]  req_rd = '0;
  logic [15:0] mem_addr;
  logic [15:0] mem_wrData;
  logic        mem_memRead;
  logic        mem_memWrite;
  logic [15:0] mem_rdData;
  logic        resp_valid;
  logic        resp_load;
  logic [3:0]  resp_rd;
  logic [15:0] resp_data;
  logic        resp_err;

  logic        preload = 1'b1;
  logic [15:0] mem     [0:255];
  logic [15:0] exp_mem [0:255];
  logic [15:0] b2b     [0:2];
  logic [15:0] got;
  int          tests  = 0;
  int          failed = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_W(16), .DATA_W(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_addr(mem_addr), .mem_wrData(mem_wrData),
    .mem_memRead(mem_memRead), .mem_memWrite(mem_memWrite), .mem_rdData(mem_rdData),
    .resp_valid(resp_valid), .resp_load(resp_load), .resp_rd(resp_rd),
    .resp_data(resp_data), .resp_err(resp_err)
  );

  function automatic logic [15:0] init_word(input int i);
    if (i == 0) return 16'h02BC;
    return 16'(i * 40503 + 4660);
  endfunction

  // Data memory: combinational read, write on the clock edge.
  assign mem_rdData = mem[mem_addr[7:0]];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
    end else if (mem_memWrite) begin
      mem[mem_addr[7:0]] <= mem_wrData;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      failed++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp_v);
    end
  endtask

  // Issue one request from a falling edge with the unit idle; returns on the response's falling edge.
  task automatic do_req(input logic [1:0] op, input logic [15:0] addr, input logic [15:0] wd,
                        input logic [3:0] rd, output logic [15:0] data_o);
    int word, lane, cur, bytev, nw;
    int exp_lat, exp_rds, exp_wrs, exp_wdat, exp_data, exp_load, exp_err;
    int n_rd, n_wr, cyc;
    logic [15:0] seen_raddr, seen_waddr, seen_wdat;
    word = int'(addr) / 2;
    lane = int'(addr) % 2;
    cur  = int'(exp_mem[word]);
    nw = cur; exp_lat = 2; exp_rds = 0; exp_wrs = 0; exp_wdat = 0;
    exp_data = 0; exp_load = 0; exp_err = 0;
    if (op[1] == 1'b0 && lane == 1) begin
      exp_err = 1;
    end else begin
      case (op)
        2'b00: begin exp_rds = 1; exp_load = 1; exp_data = cur; end
        2'b01: begin exp_wrs = 1; nw = int'(wd); end
        2'b10: begin
          exp_rds = 1; exp_load = 1;
          bytev = (lane == 1) ? cur / 256 : cur % 256;
          exp_data = (bytev >= 128) ? bytev + 65280 : bytev;
        end
        default: begin
          exp_rds = 1; exp_wrs = 1; exp_lat = 3;
          nw = (lane == 1) ? (int'(wd) % 256) * 256 + cur % 256 : (cur / 256) * 256 + int'(wd) % 256;
        end
      endcase
      if (exp_wrs == 1) exp_wdat = nw;
    end

    check("ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd; req_rd = rd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_op = 2'($urandom); req_addr = 16'($urandom); req_wdata = 16'($urandom); req_rd = 4'($urandom);
    cyc = 0; n_rd = 0; n_wr = 0;
    seen_raddr = '0; seen_waddr = '0; seen_wdat = '0;
    while (1) begin
      @(negedge clk);
      cyc++;
      if (resp_valid === 1'b1 || cyc >= 8) break;
      check("ready_busy", 32'(req_ready), 32'd0);
      check("rd_wr_excl", 32'(mem_memRead & mem_memWrite), 32'd0);
      if (mem_memRead) begin n_rd++; seen_raddr = mem_addr; end
      if (mem_memWrite) begin n_wr++; seen_waddr = mem_addr; seen_wdat = mem_wrData; end
      if (!mem_memRead && !mem_memWrite) begin
        check("quiet_addr", 32'(mem_addr), 32'd0);
        check("quiet_wdat", 32'(mem_wrData), 32'd0);
      end
    end
    check("latency", 32'(cyc), 32'(exp_lat));
    check("read_cycles", 32'(n_rd), 32'(exp_rds));
    check("write_cycles", 32'(n_wr), 32'(exp_wrs));
    if (exp_rds == 1) check("read_addr", 32'(seen_raddr), 32'(word));
    if (exp_wrs == 1) begin
      check("write_addr", 32'(seen_waddr), 32'(word));
      check("write_data", 32'(seen_wdat), 32'(exp_wdat));
    end
    check("resp_valid", 32'(resp_valid), 32'd1);
    check("resp_load", 32'(resp_load), 32'(exp_load));
    check("resp_err", 32'(resp_err), 32'(exp_err));
    check("resp_data", 32'(resp_data), 32'(exp_data));
    check("resp_rd", 32'(resp_rd), 32'(rd));
    data_o = resp_data;
    exp_mem[word] = 16'(nw);
  endtask

  initial begin
    int bad;
    for (int i = 0; i < 256; i++) exp_mem[i] = init_word(i);
    b2b[0] = 16'h0000; b2b[1] = 16'h0002; b2b[2] = 16'h0010;

    // Reset state
    #1;
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_mem_read", 32'(mem_memRead), 32'd0);
    check("rst_mem_write", 32'(mem_memWrite), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    @(posedge clk);
    @(negedge clk);
    preload = 1'b0;
    rst = 1'b1;
    @(negedge clk);

    // Loads from the preloaded word 0x02BC
    do_req(2'b00, 16'h0000, 16'h0000, 4'd5, got);
    check("lw0_value", 32'(got), 32'h02BC);
    do_req(2'b10, 16'h0000, 16'h0000, 4'd6, got);
    check("lb0_value", 32'(got), 32'hFFBC);
    do_req(2'b10, 16'h0001, 16'h0000, 4'd7, got);
    check("lb1_value", 32'(got), 32'h0002);

    // Word store, byte merge into its upper lane, read back
    do_req(2'b01, 16'h0002, 16'h1234, 4'd1, got);
    do_req(2'b11, 16'h0003, 16'h00A5, 4'd2, got);
    do_req(2'b00, 16'h0002, 16'h0000, 4'd3, got);
    check("sb_merge_value", 32'(got), 32'hA534);

    // Misaligned word accesses
    do_req(2'b00, 16'h0005, 16'h0000, 4'd4, got);
    do_req(2'b01, 16'h0007, 16'hBEEF, 4'd8, got);

    // Back-to-back loads with req_valid held high
    req_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      req_op = 2'b00; req_addr = b2b[k]; req_rd = 4'(k + 1);
      check("b2b_ready_idle", 32'(req_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      check("b2b_ready_busy", 32'(req_ready), 32'd0);
      check("b2b_read", 32'(mem_memRead), 32'd1);
      check("b2b_addr", 32'(mem_addr), 32'(b2b[k] >> 1));
      check("b2b_no_resp", 32'(resp_valid), 32'd0);
      @(posedge clk);
      @(negedge clk);
      check("b2b_resp", 32'(resp_valid), 32'd1);
      check("b2b_data", 32'(resp_data), 32'(exp_mem[b2b[k] >> 1]));
      check("b2b_rd", 32'(resp_rd), 32'(k + 1));
    end
    req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("b2b_single_pulse", 32'(resp_valid), 32'd0);

    // Reset during an SB's merge cycle aborts the write
    req_valid = 1'b1; req_op = 2'b11; req_addr = 16'h0021; req_wdata = 16'h0077; req_rd = 4'd9;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #2;
    check("merge_write_on", 32'(mem_memWrite), 32'd1);
    rst = 1'b0;
    #1;
    check("abort_write_off", 32'(mem_memWrite), 32'd0);
    check("abort_read_off", 32'(mem_memRead), 32'd0);
    check("abort_addr", 32'(mem_addr), 32'd0);
    check("abort_ready", 32'(req_ready), 32'd1);
    check("abort_resp", 32'(resp_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 32'(req_ready), 32'd1);
    check("post_rst_resp", 32'(resp_valid), 32'd0);
    do_req(2'b00, 16'h0020, 16'h0000, 4'd10, got);
    check("abort_word_kept", 32'(got), 32'(init_word(16)));

    // Random traffic over a small address window
    repeat (80) begin
      do_req(2'($urandom_range(0, 3)), 16'($urandom_range(0, 63)), 16'($urandom), 4'($urandom), got);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== exp_mem[i]) bad++;
    check("final_memory", 32'(bad), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
